// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and fills IF/ID.
// Optional FETCH_PERF_EN adds fetch_count / flush_count performance counters.
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  input  logic [31:0] instr_in,
  output logic [31:0] pc_out,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] flush_count
`endif
);

  logic [31:0] pc_plus4;
  logic [31:0] branch_target;

  assign pc_plus4      = pc_out + 32'd4;
  // Masking keeps PC word-aligned no matter what EX hands us.
  assign branch_target = branch_addr & 32'hFFFF_FFFC;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_out      <= PC_RESET & 32'hFFFF_FFFC;
      if_id_pc    <= '0;
      if_id_instr <= '0;
      if_id_valid <= 1'b0;
    end else if (branch_taken) begin
      pc_out      <= branch_target;
      if_id_pc    <= '0;
      if_id_instr <= '0;
      if_id_valid <= 1'b0;
    end else if (!freeze) begin
      pc_out      <= pc_plus4;
      if_id_pc    <= pc_plus4;
      if_id_instr <= instr_in;
      if_id_valid <= 1'b1;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else if (branch_taken) begin
      flush_count <= flush_count + 32'd1;
    end else if (!freeze) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a behavioural PC/IF-ID model pushes expectations,
// a monitor pops them one edge later and compares against the DUT outputs.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic [31:0] instr_in;
  logic [31:0] pc_out;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] flush_count;
`endif

  always #5 clk = ~clk;

  fetch_stage #(.PC_RESET(32'd0)) dut (
    .clk(clk),
    .rst(rst),
    .freeze(freeze),
    .branch_taken(branch_taken),
    .branch_addr(branch_addr),
    .instr_in(instr_in),
    .pc_out(pc_out),
    .if_id_pc(if_id_pc),
    .if_id_instr(if_id_instr),
    .if_id_valid(if_id_valid)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count(fetch_count),
    .flush_count(flush_count)
`endif
  );

  // Instruction memory contents: MOV R0,#20 at address 0, a scrambled word elsewhere.
  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'd0) return 32'hE3A00014;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
  endfunction

  assign instr_in = mem(pc_out);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ifpc;
    logic [31:0] instr;
    logic        valid;
    logic [31:0] fc;
    logic [31:0] flc;
  } exp_t;

  exp_t exp_q[$];

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model state: what the stage should hold after each edge.
  logic [31:0] m_pc = '0, m_ifpc = '0, m_instr = '0, m_fc = '0, m_flc = '0;
  logic        m_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic f, input logic b, input logic [31:0] a);
    exp_t e;
    @(negedge clk);
    rst = r; freeze = f; branch_taken = b; branch_addr = a;
    if (r) begin
      m_pc = 32'd0; m_ifpc = 0; m_instr = 0; m_valid = 0; m_fc = 0; m_flc = 0;
    end else if (b) begin
      m_pc = (a / 4) * 4; m_ifpc = 0; m_instr = 0; m_valid = 0; m_flc = m_flc + 1;
    end else if (!f) begin
      m_instr = mem(m_pc); m_ifpc = m_pc + 4; m_pc = m_pc + 4; m_valid = 1; m_fc = m_fc + 1;
    end
    e.pc = m_pc; e.ifpc = m_ifpc; e.instr = m_instr; e.valid = m_valid;
    e.fc = m_fc; e.flc = m_flc;
    exp_q.push_back(e);
  endtask

  // Monitor: compares the edge's result 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pc_out", pc_out, e.pc);
        check("if_id_pc", if_id_pc, e.ifpc);
        check("if_id_instr", if_id_instr, e.instr);
        check("if_id_valid", {31'd0, if_id_valid}, {31'd0, e.valid});
`ifdef FETCH_PERF_EN
        check("fetch_count", fetch_count, e.fc);
        check("flush_count", flush_count, e.flc);
`endif
      end
    end
  end

  initial begin
    logic r, f, b;
    logic [31:0] a;
    // Reset, free run through 0,4,8,12 then freeze 3 cycles at 12, release.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0);
    // Get to 148, then branch to 112.
    step(0, 0, 1, 32'd148);
    step(0, 0, 1, 32'd112);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    // Freeze and branch together, unaligned target.
    step(0, 1, 1, 32'h0000_00B9);
    step(0, 0, 0, 0);
    // Wrap-around from the top of the address space.
    step(0, 0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    // Counter scenario: reset, 10 normal, 2 branches, 3 freezes, reset.
    step(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
    step(0, 0, 1, 32'h0000_0040);
    step(0, 1, 1, 32'h0000_1003);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    step(1, 1, 1, 32'h0000_0100);
    step(0, 0, 0, 0);
    // Randomised traffic, including mid-stream resets.
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 99) < 2);
      f = ($urandom_range(0, 99) < 30);
      b = ($urandom_range(0, 99) < 15);
      a = (i % 37 == 5) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom;
      step(r, f, b, a);
    end
    step(0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage ARM pipeline. It owns the program counter, drives the address into the combinational instruction memory, and latches the returned instruction with its PC+4 into the IF/ID pipeline register consumed by the decode stage. It handles hazard freezes from the hazard unit and taken-branch redirects and flushes from the execute stage.

## Interface
- `PC_RESET`, default 32'd0: PC value loaded on reset.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `freeze`  in  1  hazard stall. When asserted, PC and IF/ID hold.
- `branch_taken`  in  1  taken branch resolved in EX. Redirects the PC and flushes IF/ID.
- `branch_addr`  in  32  branch target from EX, as a byte address.
- `instr_in`  in  32  instruction returned combinationally by instruction memory for `pc_out`.
- `pc_out`  out  32  current PC register; drives the instruction memory address.
- `if_id_pc`  out  32  registered PC+4 of the latched instruction.
- `if_id_instr`  out  32  registered instruction.
- `if_id_valid`  out  1  1 when `if_id_instr` is a real fetched instruction, 0 for a bubble.
- `fetch_count`  out  32  number of instructions latched valid (present only with `FETCH_PERF_EN`).
- `flush_count`  out  32  number of branch flushes (present only with `FETCH_PERF_EN`).

## Operation
- Priority per edge: `rst` > `branch_taken` > `freeze` > normal advance.
- Reset:
  - PC <= `PC_RESET` with bits [1:0] forced to 0.
  - `if_id_pc` <= 0, `if_id_instr` <= 0, `if_id_valid` <= 0, counters <= 0.
- Normal (no rst, no branch, no freeze):
  - PC <= PC+4.
  - `if_id_instr` <= `instr_in`, `if_id_pc` <= PC+4, `if_id_valid` <= 1.
- Freeze (no branch): PC, `if_id_pc`, `if_id_instr` and `if_id_valid` all hold.
- Branch taken, whether or not freeze is asserted:
  - PC <= {`branch_addr`[31:2], 2'b00}.
  - `if_id_instr` <= 0, `if_id_pc` <= 0, `if_id_valid` <= 0. The instruction fetched this cycle is discarded.
- Arithmetic: PC+4 is a 32-bit modulo add. 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- `branch_addr` low bits are ignored, so PC is always word-aligned.
- `instr_in` is sampled only at the clock edge; combinational glitches on it are irrelevant.
- No internal state machine beyond the PC and IF/ID registers. The bubble state is encoded by `if_id_valid`=0.

## Timing
- `pc_out` changes only on a clock edge and is the register output with no combinational path from any input.
- Fetch latency: the instruction at address A appears on `if_id_instr` one edge after `pc_out`=A, provided no freeze or branch occurs on that edge.
- Steady state: one instruction per cycle.
- Freeze for N cycles delays the stream by exactly N cycles; no instruction is lost or duplicated.
- Branch penalty:
  - The edge with `branch_taken`=1 produces one bubble in IF/ID.
  - The target instruction appears on `if_id_instr` one edge later.
  - The branch instruction's younger sibling in ID/EX is flushed by the downstream stage, not here.
- Back-to-back branches: each edge with `branch_taken`=1 redirects again and produces another bubble.
- `rst` asserted mid-stream: on the next edge all outputs take their reset values regardless of `freeze` or `branch_taken`.
  - First edge after `rst` deasserts: `if_id_instr`=mem[`PC_RESET`], `if_id_pc`=`PC_RESET`+4, `pc_out`=`PC_RESET`+4.

## Configuration
- `FETCH_PERF_EN` defined:
  - `fetch_count` increments on every edge that sets `if_id_valid` <= 1.
  - `flush_count` increments on every edge with `branch_taken`=1 and `rst`=0.
  - Both are 32-bit, wrap modulo 2^32, and clear on `rst`.
- `FETCH_PERF_EN` undefined: both counter ports and their registers are absent. Fetch behaviour is identical.

## Test plan
- Reset then free-run 4 cycles, with memory holding MOV R0,#20 at address 0:
  - `pc_out` steps 0, 4, 8, 12, 16.
  - After the first edge, `if_id_instr`=32'hE3A00014, `if_id_pc`=4, `if_id_valid`=1.
- Freeze 3 cycles at `pc_out`=12:
  - `pc_out` stays 12 and IF/ID stays at the instruction from address 8 with `if_id_pc`=12.
  - On release, the next edge latches the instruction at 12.
- Branch with `branch_taken`=1, `branch_addr`=112 while `pc_out`=148:
  - Next edge: `pc_out`=112, `if_id_valid`=0, `if_id_instr`=0.
  - Following edge: `if_id_instr`=mem[112], `if_id_pc`=116.
- Simultaneous `freeze`=1 and `branch_taken`=1 with `branch_addr`=32'h0000_00B9: branch wins, giving `pc_out`=184 and a bubble in IF/ID.
- Wrap-around: `branch_addr`=32'hFFFF_FFFC, then free-run. `pc_out` goes to 32'hFFFF_FFFC, then 0, with `if_id_pc`=0 for that fetch.
- `FETCH_PERF_EN` run: 10 normal cycles, 2 branches, 3 freeze cycles, then `rst`.
  - Expected `fetch_count`=10, `flush_count`=2.
  - Both read 0 one edge after `rst`.
